// File: rtl/display_driver_bcm.sv
// BCM LED-panel driver: bit-planes of each row are shifted out while the previous plane is shown,
// with plane b displayed for unit_cycles<<b clocks gated by a global brightness fraction.
module display_driver_bcm #(
  parameter int load_delay  = 1,
  parameter int segments    = 1,
  parameter int rows        = 8,
  parameter int columns     = 32,
  parameter int bitwidth    = 8,
  parameter int clk_div     = 1,
  parameter int unit_cycles = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enable,
  input  logic [7:0]                       brightness,
  input  logic [bitwidth*3*segments-1:0]   pixel,
  output logic [$clog2(rows)-1:0]          load_row,
  output logic [$clog2(columns)-1:0]       column,
  output logic [$clog2(bitwidth)-1:0]      plane,
  output logic [$clog2(rows)-1:0]          row,
  output logic [3*segments-1:0]            rgb,
  output logic                             oclk,
  output logic                             lat,
  output logic                             oe,
  output logic                             frame_complete,
  output logic                             busy
);
  localparam int RW  = $clog2(rows);
  localparam int CLW = $clog2(columns);
  localparam int PW  = $clog2(bitwidth);
  localparam int WW  = bitwidth + $clog2(unit_cycles) + 1;
  localparam int PRW = WW + 8;
  localparam int CW  = $clog2(load_delay + clk_div + 1) + 1;

  typedef enum logic [2:0] {SH_IDLE, SH_ADDR, SH_CLK_LO, SH_CLK_HI, SH_DONE} sh_state_t;
  typedef enum logic [2:0] {D_IDLE, D_LATCH, D_SHOW, D_WAIT, D_END} d_state_t;

  sh_state_t sh_state, sh_next;
  d_state_t  d_state, d_next;

  logic [CW-1:0]       sh_cnt;
  logic [WW-1:0]       timer, window, on_cycles;
  logic [PRW-1:0]      product;
  logic [PW-1:0]       disp_plane, tgt_plane;
  logic [RW-1:0]       tgt_row;
  logic                run_on, sh_start, sh_stop;
  logic                cnt_ld_end, cnt_div_end, last_col, last_latched, window_end;
  logic [3*segments-1:0] plane_bits;

  for (genvar g = 0; g < 3*segments; g++) begin : g_bits
    logic [bitwidth-1:0] ch;
    assign ch            = pixel[g*bitwidth +: bitwidth];
    assign plane_bits[g] = ch[plane];
  end

  assign cnt_ld_end   = sh_cnt == CW'(load_delay);
  assign cnt_div_end  = sh_cnt == CW'(clk_div - 1);
  assign last_col     = column == CLW'(columns - 1);
  assign last_latched = (row == RW'(rows - 1)) && (disp_plane == PW'(bitwidth - 1));

  assign window     = WW'(unit_cycles) << disp_plane;
  assign product    = PRW'(window) * PRW'(brightness);
  assign on_cycles  = WW'(product >> 8);
  assign window_end = timer == window - WW'(1);

  always_comb begin
    sh_next = sh_state;
    if (sh_start)     sh_next = SH_ADDR;
    else if (sh_stop) sh_next = SH_IDLE;
    else begin
      case (sh_state)
        SH_ADDR:   if (cnt_ld_end)  sh_next = SH_CLK_LO;
        SH_CLK_LO: if (cnt_div_end) sh_next = SH_CLK_HI;
        SH_CLK_HI: if (cnt_div_end) sh_next = last_col ? SH_DONE : SH_ADDR;
        default:   sh_next = sh_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_state <= SH_IDLE;
      sh_cnt   <= '0;
      column   <= '0;
      load_row <= '0;
      plane    <= '0;
      rgb      <= '0;
    end else begin
      sh_state <= sh_next;
      if (sh_start) begin
        sh_cnt   <= '0;
        column   <= '0;
        load_row <= tgt_row;
        plane    <= tgt_plane;
      end else if (sh_next != sh_state) begin
        sh_cnt <= '0;
      end else if (sh_state inside {SH_ADDR, SH_CLK_LO, SH_CLK_HI}) begin
        sh_cnt <= sh_cnt + CW'(1);
      end
      if (!sh_start && sh_state == SH_ADDR && cnt_ld_end)
        rgb <= plane_bits;
      if (!sh_start && sh_state == SH_CLK_HI && cnt_div_end && !last_col)
        column <= column + CLW'(1);
    end
  end

  // Shift of the following plane is launched from the LATCH cycle, so display and shift overlap.
  always_comb begin
    d_next    = d_state;
    sh_start  = 1'b0;
    sh_stop   = 1'b0;
    tgt_row   = '0;
    tgt_plane = '0;
    case (d_state)
      D_IDLE: if (enable) begin
        d_next   = D_WAIT;
        sh_start = 1'b1;
      end
      D_LATCH: begin
        d_next = D_SHOW;
        if (disp_plane == PW'(bitwidth - 1)) begin
          tgt_plane = '0;
          tgt_row   = (row == RW'(rows - 1)) ? '0 : row + RW'(1);
        end else begin
          tgt_plane = disp_plane + PW'(1);
          tgt_row   = row;
        end
        if (last_latched && !enable) sh_stop  = 1'b1;
        else                         sh_start = 1'b1;
      end
      D_SHOW: if (window_end) begin
        if (last_latched)              d_next = D_END;
        else if (sh_state == SH_DONE)  d_next = D_LATCH;
        else                           d_next = D_WAIT;
      end
      D_WAIT: if (sh_state == SH_DONE) d_next = D_LATCH;
      D_END: begin
        if (!run_on)                  d_next = D_IDLE;
        else if (sh_state == SH_DONE) d_next = D_LATCH;
        else                          d_next = D_WAIT;
      end
      default: d_next = D_IDLE;
    endcase
  end

  // row/disp_plane load on entry to LATCH so the row address moves while oe is already low.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_state    <= D_IDLE;
      timer      <= '0;
      row        <= '0;
      disp_plane <= '0;
      run_on     <= 1'b0;
    end else begin
      d_state <= d_next;
      if (d_next == D_LATCH) begin
        row        <= load_row;
        disp_plane <= plane;
      end
      if (d_state == D_LATCH) begin
        timer  <= '0;
        run_on <= !(last_latched && !enable);
      end else if (d_state == D_SHOW) begin
        timer <= timer + WW'(1);
      end
    end
  end

  assign lat            = d_state == D_LATCH;
  assign oe             = (d_state == D_SHOW) && (timer < on_cycles);
  assign frame_complete = d_state == D_END;
  assign busy           = d_state != D_IDLE;
  assign oclk           = sh_state == SH_CLK_HI;

endmodule
